// File: rtl/dontcare_pkg.sv
// dontcare_pkg: shared defaults, pointer type and DONTCARE fill helper.
// DONTCARE_X_EN selects 'x fill; otherwise the fill is '0.
package dontcare_pkg;
  localparam int DC_WIDTH = 8;
  localparam int DC_DEPTH = 4;
  localparam int DC_MAX_W = 256;
  typedef logic [$clog2(DC_DEPTH)-1:0] ptr_t;
`ifdef DONTCARE_X_EN
  localparam logic DC_BIT = 1'bx;
`else
  localparam logic DC_BIT = 1'b0;
`endif
  function automatic logic [DC_MAX_W-1:0] dc_fill(input int width);
    logic [DC_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < DC_MAX_W; i++) r[i] = (i < width) ? DC_BIT : 1'b0;
    return r;
  endfunction
endpackage

// File: rtl/dontcare_fifo_if.sv
// dontcare_fifo_if: valid/ready producer and consumer bundle plus status.
interface dontcare_fifo_if #(parameter int WIDTH = 8, parameter int DEPTH = 4);
  logic                       in_valid;
  logic [WIDTH-1:0]           in_data;
  logic                       in_ready;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH-1:0]           out_data;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       overflow;
  modport master (output in_valid, in_data, out_ready,
                  input in_ready, out_valid, out_data, count, overflow);
  modport slave (input in_valid, in_data, out_ready,
                 output in_ready, out_valid, out_data, count, overflow);
endinterface

// File: rtl/dontcare_fifo_mem.sv
// dontcare_fifo_mem: DEPTH x WIDTH registers, sync write, async read.
// Cleared on reset unless DONTCARE_X_EN is defined.
module dontcare_fifo_mem #(parameter int WIDTH = 8, parameter int DEPTH = 4) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]           rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end
`ifdef DONTCARE_X_EN
  always_ff @(posedge clock) mem_q <= mem_d;
`else
  always_ff @(posedge clock) begin
    if (!rst_n) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  end
`endif
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/dontcare_fifo.sv
// dontcare_fifo: first-word fall-through valid/ready FIFO with sticky overflow.
// DONTCARE_X_EN: out_data is 'x (else '0) while empty.
module dontcare_fifo
  import dontcare_pkg::*;
#(parameter int WIDTH = DC_WIDTH, parameter int DEPTH = DC_DEPTH) (
  input logic        clock,
  input logic        rst_n,
  dontcare_fifo_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef logic [WIDTH-1:0] data_t;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d, full, empty, push, pop;
  data_t         rdata;
  always_comb begin
    full       = count_q == CW'(DEPTH);
    empty      = count_q == '0;
    push       = bus.in_valid & ~full;
    pop        = bus.out_ready & ~empty;
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q + CW'(push) - CW'(pop);
    // a pop in the same cycle does not make room for a push while full
    overflow_d = overflow_q | (bus.in_valid & full);
  end
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end
  dontcare_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clock (clock),
    .rst_n (rst_n),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (bus.in_data),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );
  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign bus.out_data  = empty ? data_t'(dc_fill(WIDTH)) : rdata;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
endmodule
